// File: rtl/cpu_hs_pkg.sv
// ============================================================================
// cpu_hs_pkg
// Shared types and constants for the CPU-side send/ack transmitter.
//   state_t  : transmitter FSM states
//   MODE_*   : handshake style selector values
//   SENT_W   : width of the completed-transfer counter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_hs_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SETUP = 3'd2,
    REQ   = 3'd3,
    REL   = 3'd4
  } state_t;

  localparam int MODE_4PH = 0;
  localparam int MODE_2PH = 1;
  localparam int SENT_W   = 16;

endpackage

`default_nettype wire

// File: rtl/cpu_hs_fifo.sv
// ============================================================================
// cpu_hs_fifo
// Synchronous FIFO, DEPTH entries (power of two) of W bits, first-word
// visible on rdata_o while not empty.
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   push_i, wdata_i      enqueue request and data (dropped when full)
//   pop_i                dequeue request (ignored when empty)
//   rdata_o              head of queue
//   full_o, empty_o      status flags
//   count_o              occupancy, 0..DEPTH
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_hs_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop in the same cycle frees a slot, so a push against a full FIFO
  // is still accepted when it coincides with a pop.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers are AW bits wide, so wrap modulo DEPTH comes for free.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_hs_tx.sv
// ============================================================================
// cpu_hs_tx
// Buffers CPU words in a FIFO and delivers them one at a time on cpu_dados
// with a send/ack handshake (4-phase level or 2-phase toggle, set by MODE).
// cpu_ack is synchronised, each ack wait is bounded by TIMEOUT cycles.
// Ports:
//   cpu_clock, cpu_reset   clock, synchronous active-low reset
//   wr_en, wr_data         CPU push interface
//   full, empty, count     FIFO status
//   cpu_send, cpu_ack      handshake request / asynchronous acknowledge
//   cpu_dados              word being delivered
//   busy                   FSM not idle
//   err_timeout            sticky ack-timeout flag
//   sent_cnt               completed transfers, wraps
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_hs_tx
  import cpu_hs_pkg::*;
#(
  parameter int W           = 4,
  parameter int DEPTH       = 8,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                   cpu_clock,
  input  logic                   cpu_reset,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   cpu_send,
  input  logic                   cpu_ack,
  output logic [W-1:0]           cpu_dados,
  output logic                   busy,
  output logic                   err_timeout,
  output logic [SENT_W-1:0]      sent_cnt
);

  // Wait counter only has to reach TIMEOUT-1 before the timeout fires.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                   state_q, state_d;
  logic                     send_q, send_d;
  logic [W-1:0]             dados_q, dados_d;
  logic                     err_q, err_d;
  logic [SENT_W-1:0]        sent_q, sent_d;
  logic [WAIT_W-1:0]        wait_q, wait_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     ack_s;
  logic                     pop;
  logic                     timeout_hit;
  logic [W-1:0]             fifo_rdata;

  cpu_hs_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (cpu_clock),
    .rst_ni  (cpu_reset),
    .push_i  (wr_en),
    .wdata_i (wr_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign ack_s       = sync_q[SYNC_STAGES-1];
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT - 1));

  assign cpu_send    = send_q;
  assign cpu_dados   = dados_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_q;
  assign sent_cnt    = sent_q;

  always_ff @(posedge cpu_clock) begin
    if (!cpu_reset) begin
      state_q <= IDLE;
      send_q  <= 1'b0;
      dados_q <= '0;
      err_q   <= 1'b0;
      sent_q  <= '0;
      wait_q  <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      send_q  <= send_d;
      dados_q <= dados_d;
      err_q   <= err_d;
      sent_q  <= sent_d;
      wait_q  <= wait_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], cpu_ack};
    end
  end

  always_comb begin
    state_d = state_q;
    send_d  = send_q;
    dados_d = dados_q;
    err_d   = err_q;
    sent_d  = sent_q;
    wait_d  = wait_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) state_d = LOAD;
      end
      LOAD: begin
        dados_d = fifo_rdata;
        pop     = 1'b1;
        state_d = SETUP;
      end
      SETUP: begin
        // Request is registered on the way into REQ, so the data word
        // has already been stable for a full cycle when it appears.
        wait_d  = '0;
        send_d  = (MODE == MODE_2PH) ? ~send_q : 1'b1;
        state_d = REQ;
      end
      REQ: begin
        if ((MODE == MODE_2PH) ? (ack_s == send_q) : ack_s) begin
          if (MODE == MODE_2PH) begin
            sent_d  = sent_q + 1'b1;
            state_d = IDLE;
          end else begin
            send_d  = 1'b0;
            wait_d  = '0;
            state_d = REL;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
          if (MODE != MODE_2PH) send_d = 1'b0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      REL: begin
        if (!ack_s) begin
          sent_d  = sent_q + 1'b1;
          state_d = IDLE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/cpu_hs_tx.md
Name: cpu_hs_tx

Overview:
- Parametrised successor to the CPU-side send/ack data transmitter.
- Buffers words from the CPU core in a DEPTH-entry FIFO and delivers them one at a time on cpu_dados using a send/ack handshake.
- The handshake is either 4-phase (level) or 2-phase (toggle); MODE selects which.
- Adds a synchroniser on cpu_ack (the receiver is asynchronous), an ack timeout with a sticky error flag, and word/occupancy counters.

Parameters:
- W, 4: data width of cpu_dados and wr_data.
- DEPTH, 8: FIFO entries; must be a power of two, at least 2.
- MODE, 0: 0 = 4-phase level handshake; 1 = 2-phase toggle handshake.
- SYNC_STAGES, 2: flip-flop stages on cpu_ack; at least 2.
- TIMEOUT, 255: cycles allowed per ack wait before the error is raised; 0 disables the timeout.

Ports:
- cpu_clock  in  1  single clock; all state on the rising edge.
- cpu_reset  in  1  synchronous, active-low reset.
- wr_en  in  1  push wr_data into the FIFO; ignored when full.
- wr_data  in  W  word to enqueue.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- cpu_send  out  1  handshake request to the receiver.
- cpu_ack  in  1  asynchronous acknowledge from the receiver.
- cpu_dados  out  W  data word; stable while a transfer is in progress.
- busy  out  1  state is not IDLE.
- err_timeout  out  1  sticky; cleared only by reset.
- sent_cnt  out  16  completed transfers; wraps modulo 2^16.

Behaviour:
Reset (cpu_reset=0 at a clock edge):
- All outputs 0: cpu_send, cpu_dados, busy, err_timeout, sent_cnt, count and full are 0; empty is 1.
- FIFO pointers and synchroniser flops are cleared; the state returns to IDLE.
- Reset in mid-transfer abandons the word and drops cpu_send in the same edge.

FIFO:
- Push occurs when wr_en=1 and full=0. A push while full is dropped silently; count does not change.
- Pop is done internally in LOAD.
- A push and a pop in the same cycle leave count unchanged and are legal even when full, because the pop frees the slot first.
- Pointers wrap modulo DEPTH.

Ack synchroniser:
- ack_s is cpu_ack delayed by SYNC_STAGES cycles. The FSM uses only ack_s.

FSM:
- IDLE: if empty=0, go to LOAD.
- LOAD: cpu_dados <= FIFO head; pop; go to SETUP.
- SETUP: one cycle of data setup before the request; go to REQ.
- REQ (4-phase): cpu_send=1. When ack_s=1, go to REL.
- REL (4-phase): cpu_send=0. When ack_s=0, increment sent_cnt and go to IDLE.
- 2-phase (MODE=1):
  - SETUP toggles cpu_send.
  - REQ waits for ack_s == cpu_send, then increments sent_cnt and goes to IDLE.
  - REL is unused.
  - cpu_send is not returned to 0 between words.
- cpu_dados holds its value from LOAD until the next LOAD. It never changes while cpu_send is asserted (4-phase) or while an ack is pending (2-phase).

Timeout:
- A wait counter clears on entry to REQ and to REL, and increments every cycle spent waiting.
- When it reaches TIMEOUT: err_timeout <= 1, cpu_send returns to its idle level (0 in 4-phase; unchanged in 2-phase), the word is discarded without incrementing sent_cnt, and the state goes to IDLE.
- Transfers continue after a timeout. The flag stays set.

Minimum cycle cost (4-phase, receiver acks immediately):
- LOAD + SETUP + REQ (1 + SYNC_STAGES) + REL (1 + SYNC_STAGES) = 8 cycles per word at SYNC_STAGES=2.
- Back-to-back words need no extra idle cycle beyond IDLE.

Decomposition:
- Shared package cpu_hs_pkg holds:
  - state enum: IDLE, LOAD, SETUP, REQ, REL;
  - MODE_4PH=0 and MODE_2PH=1 constants;
  - the sent_cnt width constant (16).
- One natural sub-module: cpu_hs_fifo, a synchronous FIFO parametrised by W and DEPTH with full, empty and count outputs. The synchroniser and FSM stay in cpu_hs_tx.

Test Plan:
- Reset: hold cpu_reset=0 for 3 cycles with wr_en=1 -> cpu_send=0, count=0, empty=1, sent_cnt=0. After release, a push of 4'hA gives count=1 one cycle later.
- 4-phase single word: push 4'h5; the bench acks 2 cycles after cpu_send rises and releases 2 cycles after cpu_send falls. Required:
  - cpu_dados=4'h5 before cpu_send rises;
  - cpu_send falls exactly SYNC_STAGES+1 cycles after ack rises;
  - sent_cnt=1; busy returns to 0.
- Full/overflow: DEPTH=8, ack held 0, 10 pushes of 1..10 -> word 1 is in flight and 2..9 fill the FIFO (full=1, count=8); push 10 is dropped. After acking everything, the delivered order is 1..9 and sent_cnt=9.
- Timeout: TIMEOUT=20, push 4'h3, never ack -> 20 cycles after REQ entry, err_timeout=1, cpu_send=0, sent_cnt unchanged. A following word 4'h4 with a normal ack completes and err_timeout stays 1.
- 2-phase: MODE=1, push 4'h1, 4'h2, 4'h3; the bench mirrors cpu_send onto cpu_ack after 3 cycles -> cpu_send toggles 0→1→0→1, cpu_dados is 1, 2, 3 in order, sent_cnt=3.
- Reset mid-transfer: cpu_reset=0 while in REQ with cpu_send=1 -> at the next edge cpu_send=0, state is IDLE, FIFO is empty, err_timeout=0.
